// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
//   MODE_*  : operation select values for the mode input
//   ST_*    : controller state encoding
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide ripple-carry slice.
//   x, y : digit operands
//   ci   : carry into the least significant bit
//   s    : digit sum
//   co   : carry out of the most significant bit
//   cm   : carry into the most significant bit (co ^ cm flags signed overflow)
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];
  assign cm = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB digit first.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only while idle; mode/a/b/cin latched with it
//   mode     : 0 = a + b + cin, 1 = a - b - cin
//   busy     : high while an operation is in flight (RUN or DONE)
//   done     : one-cycle pulse, result/cout/ovf valid from that cycle on
//   result   : WIDTH-bit result modulo 2^WIDTH
//   cout     : carry out (add) or borrow out (subtract)
//   ovf      : two's-complement signed overflow
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] a_next, b_next, r_next;
  logic [DIGIT-1:0] sum_d;
  logic             co_d, cm_d;

  // Subtraction is a + ~b + ~cin: b is inverted on load and the carry
  // register seeded with ~cin, so the slice only ever adds.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .ci (carry),
    .s  (sum_d),
    .co (co_d),
    .cm (cm_d)
  );

  // Operands shift right one digit per cycle; each new sum digit enters at
  // the top so the full result is aligned after NDIG cycles.
  if (NDIG == 1) begin : g_single
    assign a_next = a_sh;
    assign b_next = b_sh;
    assign r_next = sum_d;
  end else begin : g_multi
    assign a_next = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_next = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    assign r_next = {sum_d, r_sh[WIDTH-1:DIGIT]};
  end

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the datapath shift registers and carry are deliberately not reset;
  // they are always loaded on start before anything reads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= (mode == MODE_SUB) ? ~b : b;
            carry  <= (mode == MODE_SUB) ? ~cin : cin;
            mode_q <= mode;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_next;
          b_sh  <= b_next;
          r_sh  <= r_next;
          carry <= co_d;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= r_next;
            // Final carry is an inverted borrow when subtracting.
            cout   <= (mode_q == MODE_SUB) ? ~co_d : co_d;
            // Carry into MSB differing from carry out of MSB is exactly the
            // sign-overflow condition of the internal addition.
            ovf    <= co_d ^ cm_d;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: three configurations (16/4, 8/8,
// 32/1), directed vectors with hand-computed results, start-while-busy and
// mid-run reset scenarios, and random operands against a behavioural model.
module tb_addsub_serial;

  localparam int NC = 3;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          start_cyc;
  } exp_t;

  int wid  [NC] = '{16, 8, 32};
  int ndig [NC] = '{4, 1, 32};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start_v [NC];
  logic        mode_v  [NC];
  logic        cin_v   [NC];
  logic [31:0] a_v     [NC];
  logic [31:0] b_v     [NC];
  logic        busy_v  [NC];
  logic        done_v  [NC];
  logic        cout_v  [NC];
  logic        ovf_v   [NC];
  logic [15:0] res0;
  logic [7:0]  res1;
  logic [31:0] res2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(res0),
    .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .result(res1),
    .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  addsub_serial #(.WIDTH(32), .DIGIT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .result(res2),
    .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] res_of(input int i);
    case (i)
      0:       return {16'h0, res0};
      1:       return {24'h0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int i, output exp_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Behavioural reference: plain integer a +/- b +/- cin at width w.
  function automatic exp_t model(input int w, input logic m, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    exp_t e;
    longint unsigned mask, au, bu, full;
    logic am, bm, rm;
    mask = (64'd1 << w) - 64'd1;
    au   = {32'h0, a} & mask;
    bu   = {32'h0, b} & mask;
    if (m == 1'b0) begin
      full = au + bu + {63'h0, c};
      e.co = full[w];
    end else begin
      full = au - bu - {63'h0, c};
      e.co = (au < bu + {63'h0, c});
    end
    e.res = 32'(full & mask);
    am = au[w-1];
    bm = bu[w-1];
    rm = full[w-1];
    e.ov = (m == 1'b0) ? (am == bm && rm != am) : (am != bm && rm != am);
    e.start_cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (done_v[i] === 1'b1) begin
        exp_t e;
        if (qsize(i) == 0) begin
          check($sformatf("cfg%0d unexpected_done", i), 1, 0);
        end else begin
          qpop(i, e);
          check($sformatf("cfg%0d result", i), res_of(i), e.res);
          check($sformatf("cfg%0d cout", i), cout_v[i], e.co);
          check($sformatf("cfg%0d ovf", i), ovf_v[i], e.ov);
          check($sformatf("cfg%0d latency", i), cyc - e.start_cyc, ndig[i] + 1);
        end
      end
    end
  end

  // Issue one operation; glitch > 0 re-asserts start (with other operands)
  // during busy cycle 'glitch', which must be ignored.
  task automatic run_op(input int i, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic c,
                        input logic [31:0] eres, input logic eco, input logic eov,
                        input int glitch);
    exp_t e;
    bit   ok;
    int   lat;
    lat = ndig[i] + 1;
    @(negedge clk);
    start_v[i] = 1'b1;
    mode_v[i]  = m;
    a_v[i]     = a;
    b_v[i]     = b;
    cin_v[i]   = c;
    e.res = eres;
    e.co  = eco;
    e.ov  = eov;
    e.start_cyc = cyc;
    qpush(i, e);
    ok = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (busy_v[i] !== 1'b1) ok = 1'b0;
      a_v[i]     = ~a;
      b_v[i]     = a ^ 32'h5a5a_5a5a;
      mode_v[i]  = ~m;
      cin_v[i]   = ~c;
      start_v[i] = (k == glitch);
    end
    check($sformatf("cfg%0d busy_window", i), ok, 1);
    @(negedge clk);
    start_v[i] = 1'b0;
    check($sformatf("cfg%0d busy_after", i), busy_v[i], 0);
    check($sformatf("cfg%0d done_after", i), done_v[i], 0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic        rm, rc;

    for (int i = 0; i < NC; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      cin_v[i]   = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      check($sformatf("cfg%0d reset busy", i), busy_v[i], 0);
      check($sformatf("cfg%0d reset done", i), done_v[i], 0);
      check($sformatf("cfg%0d reset result", i), res_of(i), 0);
      check($sformatf("cfg%0d reset cout", i), cout_v[i], 0);
      check($sformatf("cfg%0d reset ovf", i), ovf_v[i], 0);
    end

    // Directed vectors, 16-bit / 4-bit digits.
    //     cfg mode  a           b           cin   result      cout  ovf
    run_op(0, 1'b1, 32'h0008, 32'h0002, 1'b0, 32'h0006, 1'b0, 1'b0, 0);
    run_op(0, 1'b1, 32'h0008, 32'h0002, 1'b1, 32'h0005, 1'b0, 1'b0, 0);
    run_op(0, 1'b1, 32'h0030, 32'h000F, 1'b0, 32'h0021, 1'b0, 1'b0, 0);
    run_op(0, 1'b1, 32'h0002, 32'h0FFB, 1'b0, 32'hF007, 1'b1, 1'b0, 0);
    run_op(0, 1'b0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 0);
    run_op(0, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 0);
    run_op(0, 1'b1, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b0, 1'b1, 0);

    // Start re-asserted during RUN, then during DONE: both ignored.
    run_op(0, 1'b0, 32'h1234, 32'h1111, 1'b0, 32'h2345, 1'b0, 1'b0, 2);
    run_op(0, 1'b1, 32'h0010, 32'h0001, 1'b1, 32'h000E, 1'b0, 1'b0, 5);

    // Reset in the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    start_v[0] = 1'b1;
    mode_v[0]  = 1'b0;
    a_v[0]     = 32'h0100;
    b_v[0]     = 32'h0200;
    cin_v[0]   = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy_v[0], 0);
    check("abort done", done_v[0], 0);
    check("abort result", res0, 0);
    check("abort cout", cout_v[0], 0);
    check("abort ovf", ovf_v[0], 0);
    repeat (8) @(negedge clk);
    run_op(0, 1'b0, 32'h00FF, 32'h0F01, 1'b1, 32'h1001, 1'b0, 1'b0, 0);

    // Random operands on every configuration against the reference model.
    for (int i = 0; i < NC; i++) begin
      int n;
      n = (i == 0) ? 200 : 1000;
      for (int k = 0; k < n; k++) begin
        ra = $urandom;
        rb = $urandom;
        rm = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        e  = model(wid[i], rm, ra, rb, rc);
        run_op(i, rm, ra, rb, rc, e.res, e.co, e.ov, 0);
      end
    end

    repeat (5) @(negedge clk);
    check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
